// File: rtl/elixirchip_es1_spu_lut_arbiter.sv
// Round-robin arbiter sharing one fixed-latency LUT between NUM_REQ requesters.
// Requester IDs ride a shift register beside the LUT; results return in order through a credit-guarded FIFO.
module elixirchip_es1_spu_lut_arbiter #(
    parameter int    NUM_REQ    = 4,
    parameter int    LATENCY    = 1,
    parameter int    ADDR_BITS  = 6,
    parameter int    DATA_BITS  = 1,
    parameter int    ID_BITS    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int    FIFO_DEPTH = LATENCY + 2,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cke,
    input  logic [NUM_REQ*ADDR_BITS-1:0] s_addr,
    input  logic [NUM_REQ-1:0]           s_valid,
    output logic [NUM_REQ-1:0]           s_ready,
    output logic [ADDR_BITS-1:0]         lut_addr,
    output logic                         lut_valid,
    output logic                         lut_clear,
    input  logic [DATA_BITS-1:0]         lut_data,
    output logic [DATA_BITS-1:0]         m_data,
    output logic [ID_BITS-1:0]           m_id,
    output logic                         m_valid,
    input  logic                         m_ready
);

    localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_BITS = $clog2(FIFO_DEPTH + LATENCY + 1);

    logic [ID_BITS-1:0]           ptr;
    logic [ID_BITS-1:0]           grant;
    logic [ID_BITS-1:0]           sel;
    logic                         found;
    logic                         credit;
    logic                         issue;
    logic                         push;
    logic                         pop;
    logic                         push_vld;
    logic [ID_BITS-1:0]           push_id;
    logic [OCC_BITS-1:0]          inflight;
    logic [OCC_BITS-1:0]          occ;
    logic [CNT_BITS-1:0]          fifo_count;
    logic [PTR_BITS-1:0]          wr_ptr;
    logic [PTR_BITS-1:0]          rd_ptr;
    logic [DATA_BITS+ID_BITS-1:0] mem [FIFO_DEPTH];

    // Pass-through parameters belong to the LUT instance; nothing here depends on them.
    if (DEVICE == "" || SIMULATION == "" || DEBUG == "") begin : g_passthru
    end

    always_comb begin
        found = 1'b0;
        grant = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && s_valid[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                grant = ID_BITS'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    // Everything issued and not yet popped holds a credit, so the FIFO can never overflow.
    assign occ       = OCC_BITS'(fifo_count) + inflight;
    assign credit    = (occ < OCC_BITS'(FIFO_DEPTH));
    assign issue     = reset_n & cke & credit & (|s_valid);
    assign s_ready   = issue ? (NUM_REQ'(1) << grant) : '0;
    assign sel       = issue ? grant : ptr;
    assign lut_addr  = s_addr[int'(sel)*ADDR_BITS +: ADDR_BITS];
    assign lut_valid = issue;
    assign lut_clear = ~issue;

    if (LATENCY == 0) begin : g_lat0
        assign push_vld = issue;
        assign push_id  = grant;
        assign inflight = '0;
    end else begin : g_pipe
        logic [LATENCY-1:0] pipe_vld;
        logic [ID_BITS-1:0] pipe_id [LATENCY];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pipe_vld <= '0;
                for (int i = 0; i < LATENCY; i++) pipe_id[i] <= '0;
            end else if (cke) begin
                pipe_vld[0] <= issue;
                pipe_id[0]  <= grant;
                for (int i = 1; i < LATENCY; i++) begin
                    pipe_vld[i] <= pipe_vld[i-1];
                    pipe_id[i]  <= pipe_id[i-1];
                end
            end
        end

        always_comb begin
            inflight = '0;
            for (int i = 0; i < LATENCY; i++) inflight = inflight + OCC_BITS'(pipe_vld[i]);
        end

        assign push_vld = pipe_vld[LATENCY-1];
        assign push_id  = pipe_id[LATENCY-1];
    end

    assign push    = cke & push_vld;
    assign m_valid = (fifo_count != '0);
    assign pop     = cke & m_valid & m_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (cke) begin
            if (issue) ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            if (push) wr_ptr <= (int'(wr_ptr) == FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (int'(rd_ptr) == FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {lut_data, push_id};
    end

    assign {m_data, m_id} = mem[rd_ptr];

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        push |-> (fifo_count < CNT_BITS'(FIFO_DEPTH)));

endmodule

// File: tb/tb_elixirchip_es1_spu_lut_arbiter.sv
// Scoreboard bench: round-robin/credit reference model predicts grants, a monitor checks results in order.
// A second LATENCY=0 instance covers the combinational-LUT corner.
module tb_elixirchip_es1_spu_lut_arbiter;

    localparam int N  = 4;
    localparam int AB = 6;
    localparam int DB = 6;
    localparam int IB = 2;
    localparam int D  = 3;

    typedef struct {
        logic [DB-1:0] d;
        logic [IB-1:0] id;
    } item_t;

    logic          clk, reset_n, cke, m_ready;
    logic [N*AB-1:0] s_addr;
    logic [N-1:0]  s_valid, s_ready, last_ready;
    logic [AB-1:0] lut_addr;
    logic          lut_valid, lut_clear, m_valid;
    logic [DB-1:0] lut_data, m_data;
    logic [IB-1:0] m_id;

    logic [N*AB-1:0] s_addr_z;
    logic [N-1:0]  s_valid_z, s_ready_z;
    logic [AB-1:0] lut_addr_z;
    logic          lut_valid_z, lut_clear_z, m_valid_z, m_ready_z;
    logic [DB-1:0] m_data_z;
    logic [IB-1:0] m_id_z;

    int    checks = 0;
    int    errors = 0;
    int    rr = 0;
    int    outstanding = 0;
    bit    chk_hold = 0;
    item_t sb[$];

    elixirchip_es1_spu_lut_arbiter #(.NUM_REQ(N), .LATENCY(1), .ADDR_BITS(AB), .DATA_BITS(DB),
        .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .cke(cke), .s_addr(s_addr), .s_valid(s_valid),
        .s_ready(s_ready), .lut_addr(lut_addr), .lut_valid(lut_valid), .lut_clear(lut_clear),
        .lut_data(lut_data), .m_data(m_data), .m_id(m_id), .m_valid(m_valid), .m_ready(m_ready));

    elixirchip_es1_spu_lut_arbiter #(.NUM_REQ(N), .LATENCY(0), .ADDR_BITS(AB), .DATA_BITS(DB),
        .FIFO_DEPTH(2)) dut_z (
        .clk(clk), .reset_n(reset_n), .cke(1'b1), .s_addr(s_addr_z), .s_valid(s_valid_z),
        .s_ready(s_ready_z), .lut_addr(lut_addr_z), .lut_valid(lut_valid_z), .lut_clear(lut_clear_z),
        .lut_data(lut_addr_z ^ 6'd1), .m_data(m_data_z), .m_id(m_id_z), .m_valid(m_valid_z),
        .m_ready(m_ready_z));

    always #5 clk = ~clk;

    // LUT model: table[k] = k ^ 1, one cycle of latency, cleared when idle, frozen by cke.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lut_data <= '0;
        else if (cke) lut_data <= lut_clear ? '0 : (lut_addr ^ 6'd1);
    end

    a_hold : assert property (@(posedge clk) disable iff (!reset_n || !chk_hold)
        (($past(s_valid & ~s_ready) & ~s_valid) == '0))
        else begin errors++; $display("FAIL hold s_valid dropped before s_ready"); end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge with inputs already driven; predicts this cycle's grant.
    task automatic tick();
        int g;
        logic exp_iss;
        logic [N-1:0] exp_r;
        #2;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && s_valid[(rr + k) % N]) g = (rr + k) % N;
        exp_iss = reset_n && cke && (outstanding < D) && (g >= 0);
        exp_r = exp_iss ? (4'b0001 << g) : 4'b0000;
        chk("s_ready", s_ready, exp_r);
        chk("lut_valid", lut_valid, exp_iss);
        if (exp_iss) begin
            chk("lut_addr", lut_addr, s_addr[g*AB +: AB]);
            sb.push_back('{s_addr[g*AB +: AB] ^ 6'd1, IB'(g)});
            outstanding++;
            rr = (g + 1) % N;
        end
        last_ready = s_ready;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        item_t e;
        if (reset_n && cke && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got data %0h id %0h expected none", m_data, m_id);
            end else begin
                e = sb.pop_front();
                chk("m_data", m_data, e.d);
                chk("m_id", m_id, e.id);
            end
            outstanding--;
        end
    end

    initial begin
        int a, n, gz;
        logic [DB-1:0] md;
        logic [IB-1:0] mi;
        clk = 0; reset_n = 0; cke = 1; m_ready = 1; s_valid = '1; s_addr = '0;
        s_valid_z = '1; s_addr_z = '0; m_ready_z = 1; last_ready = '0;
        #12;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_lut_valid", lut_valid, 0);
        chk("rst_lut_clear", lut_clear, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_z_s_ready", s_ready_z, 0);
        chk("rst_z_m_valid", m_valid_z, 0);
        reset_n = 1; s_valid = '0; s_valid_z = '0;
        @(posedge clk); #1;

        // LATENCY=0 instance: result visible the cycle after issue, two credits
        s_valid_z = 4'b1000; s_addr_z[3*AB +: AB] = 6'd7;
        #2; chk("z_s_ready", s_ready_z, 4'b1000); chk("z_m_valid0", m_valid_z, 0);
        @(posedge clk); #1; s_valid_z = '0;
        chk("z_m_valid1", m_valid_z, 1); chk("z_m_data", m_data_z, 6'd6); chk("z_m_id", m_id_z, 3);
        @(posedge clk); #1; chk("z_m_valid_drain", m_valid_z, 0);
        m_ready_z = 0; s_valid_z = 4'b0010; s_addr_z[AB +: AB] = 6'd10; gz = 0;
        for (int k = 0; k < 4; k++) begin
            #2; if (s_ready_z != 0) gz++;
            @(posedge clk); #1;
        end
        chk("z_credit_grants", gz, 2);
        chk("z_head_data", m_data_z, 6'd11); chk("z_head_id", m_id_z, 1);
        s_valid_z = '0; m_ready_z = 1;
        repeat (3) @(posedge clk); #1;
        chk("z_drained", m_valid_z, 0);

        // req2 back-to-back lookups
        s_valid = 4'b0100; s_addr[2*AB +: AB] = 6'd5; tick();
        s_addr[2*AB +: AB] = 6'd9; chk("t1_m_valid0", m_valid, 0); tick();
        s_valid = '0;
        chk("t1_m_valid1", m_valid, 1); chk("t1_data0", m_data, 6'd4); chk("t1_id0", m_id, 2); tick();
        chk("t1_m_valid2", m_valid, 1); chk("t1_data1", m_data, 6'd8); chk("t1_id1", m_id, 2); tick();
        chk("t1_m_valid3", m_valid, 0);

        // all requesters active, with a three-cycle cke freeze in the middle
        s_addr = {6'd40, 6'd30, 6'd20, 6'd10}; s_valid = '1;
        repeat (6) tick();
        md = m_data; mi = m_id; cke = 0;
        repeat (3) begin
            tick();
            chk("t4_m_valid", m_valid, 1); chk("t4_m_data", m_data, md); chk("t4_m_id", m_id, mi);
        end
        cke = 1;
        repeat (6) tick();
        s_valid = '0;
        repeat (4) tick();

        // backpressure: only FIFO_DEPTH grants, then in-order drain
        m_ready = 0; a = 0; s_valid = 4'b0001; s_addr[0 +: AB] = 6'd0;
        repeat (6) begin
            tick();
            if (last_ready[0]) begin a++; s_addr[0 +: AB] = AB'(a); end
        end
        chk("t3_stall_grants", a, 3);
        m_ready = 1; n = 0;
        while (a < 8 && n < 40) begin
            tick(); n++;
            if (last_ready[0]) begin
                a++;
                if (a < 8) s_addr[0 +: AB] = AB'(a); else s_valid = '0;
            end
        end
        chk("t3_all_sent", a, 8);
        s_valid = '0;
        repeat (5) tick();

        // reset with lookups in flight and results buffered
        m_ready = 0; s_valid = '1;
        repeat (3) tick();
        #2; reset_n = 0; #1;
        chk("t5_m_valid", m_valid, 0); chk("t5_lut_valid", lut_valid, 0);
        chk("t5_s_ready", s_ready, 0); chk("t5_lut_clear", lut_clear, 1);
        sb.delete(); outstanding = 0; rr = 0;
        @(posedge clk); #1;
        reset_n = 1; m_ready = 1;
        tick();
        chk("t5_first_grant", last_ready, 4'b0001);
        repeat (3) tick();
        s_valid = '0;
        repeat (5) tick();

        // randomized traffic with random backpressure and clock-enable gaps
        chk_hold = 1;
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!s_valid[i] || last_ready[i]) begin
                    s_valid[i] = ($urandom % 3) != 0;
                    s_addr[i*AB +: AB] = AB'($urandom);
                end
            end
            m_ready = ($urandom % 4) != 0;
            cke = ($urandom % 8) != 0;
            tick();
        end
        chk_hold = 0;
        s_valid = '0; m_ready = 1; cke = 1;
        for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
        repeat (3) tick();
        chk("drain_empty", sb.size(), 0);
        chk("drain_m_valid", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
